// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: FSM state codes, default watchdog timeout and grant-id width helper.
package uart_tx_arbiter_pkg;
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam int DEF_BUSY_TIMEOUT = 16;
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: producer-side byte handshake plus the uart_tx write/busy link.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_write_en;
  logic [7:0]           uart_data;
  logic                 uart_busy;
  modport slave (
    input  req_valid, req_data, req_last, uart_busy,
    output req_ready, uart_write_en, uart_data
  );
  modport master (
    output req_valid, req_data, req_last, uart_busy,
    input  req_ready, uart_write_en, uart_data
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_arb_rr_pick: combinational rotate-priority picker, first set request at or after ptr (mod N).
module uart_arb_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]        req,
  input  logic [id_w(N)-1:0]  ptr,
  output logic [id_w(N)-1:0]  sel,
  output logic                any
);
  localparam int IW = id_w(N);
  logic [IW-1:0] idx;
  // Scan from farthest to nearest so the entry closest to ptr wins.
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin sharing of one uart_tx among NUM_REQ byte producers.
// Optional busy-rise watchdog enabled by defining UART_ARB_WATCHDOG_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  uart_tx_arbiter_if.slave          bus,
  output logic [id_w(NUM_REQ)-1:0]  grant_id,
  output logic                      locked,
  output logic                      err_timeout
);
  localparam int IW = id_w(NUM_REQ);

  if (NUM_REQ < 1 || BUSY_TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ and BUSY_TIMEOUT must be >= 1");
  end

  logic [1:0]    state_q, state_d;
  logic          locked_q, locked_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [7:0]    data_q, data_d;
  logic          write_en_q, write_en_d;
  logic          err_q, err_d;
  logic [IW-1:0] pick_sel, sel, sel_next;
  logic          pick_any, cand, go, sel_last, timeout;

  uart_arb_rr_pick #(.N(NUM_REQ)) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .sel (pick_sel),
    .any (pick_any)
  );

  // A held lock pins the choice to the owner even when it has nothing to send.
  assign sel      = locked_q ? owner_q : pick_sel;
  assign cand     = locked_q ? bus.req_valid[owner_q] : pick_any;
  assign go       = (state_q == ST_IDLE) && !bus.uart_busy && cand;
  assign sel_last = bus.req_last[sel];
  assign sel_next = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;

  assign bus.req_ready     = go ? (NUM_REQ'(1) << sel) : '0;
  assign bus.uart_write_en = write_en_q;
  assign bus.uart_data     = data_q;
  assign grant_id          = grant_q;
  assign locked            = locked_q;
  assign err_timeout       = err_q;

`ifdef UART_ARB_WATCHDOG_EN
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  logic [CW-1:0] wd_q, wd_d;
  assign timeout = (state_q == ST_WAIT_BUSY) && !bus.uart_busy && (wd_q == CW'(BUSY_TIMEOUT - 1));
  assign wd_d    = ((state_q == ST_WAIT_BUSY) && !bus.uart_busy && !timeout) ? wd_q + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = go ? ST_WAIT_BUSY
               : (state_q == ST_WAIT_BUSY && bus.uart_busy) ? ST_WAIT_DONE
               : ((state_q == ST_WAIT_BUSY && timeout) || (state_q == ST_WAIT_DONE && !bus.uart_busy)) ? ST_IDLE
               : state_q;
    write_en_d = go;
    data_d     = go ? bus.req_data[{sel, 3'b000} +: 8] : data_q;
    grant_d    = go ? sel : grant_q;
    owner_d    = go ? sel : owner_q;
    locked_d   = go ? !sel_last : locked_q;
    rr_ptr_d   = (go && sel_last) ? sel_next : rr_ptr_q;
    err_d      = err_q | timeout;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      locked_q   <= 1'b0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      data_q     <= '0;
      write_en_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      locked_q   <= locked_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      write_en_q <= write_en_d;
      err_q      <= err_d;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven scoreboard bench for uart_tx_arbiter with a behavioural uart_tx.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  typedef struct packed {
    logic [0:0] id;
    logic [7:0] data;
    logic       locked;
  } exp_t;

  typedef struct {
    int         phase;
    int         src;
    logic [7:0] d;
    logic       last;
    exp_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(2)) bus ();
  logic [0:0] grant_id;
  logic       locked;
  logic       err_timeout;

  uart_tx_arbiter #(.NUM_REQ(2), .BUSY_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .grant_id    (grant_id),
    .locked      (locked),
    .err_timeout (err_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // uart_tx model: busy rises the cycle after write_en and stays high 10 cycles.
  int busy_cnt;
  logic stuck = 1'b0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) busy_cnt <= 0;
    else if (bus.uart_write_en && !stuck) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  assign bus.uart_busy = (busy_cnt != 0);

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  exp_t       sb[$];
  logic [1:0] fire = '0;
  int         fires0 = 0;

  // Producers: retire accepted bytes after the edge, present the next, then note what will fire.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      if (fire[0] && q0.size() != 0) void'(q0.pop_front());
      if (fire[1] && q1.size() != 0) void'(q1.pop_front());
      bus.req_valid[0] = (q0.size() != 0);
      bus.req_valid[1] = (q1.size() != 0);
      if (q0.size() != 0) begin
        bus.req_data[7:0] = q0[0][7:0];
        bus.req_last[0]   = q0[0][8];
      end
      if (q1.size() != 0) begin
        bus.req_data[15:8] = q1[0][7:0];
        bus.req_last[1]    = q1[0][8];
      end
      #1;
      fire = bus.req_valid & bus.req_ready;
      if (fire[0]) fires0++;
      if (rst_n) begin
        chk("ready_onehot", 32'($onehot0(bus.req_ready)), 1);
        chk("ready_without_valid", 32'(bus.req_ready & ~bus.req_valid), 0);
      end
    end
  end

  int   writes = 0;
  logic prev_busy = 1'b0;
  logic prev_we = 1'b0;
  exp_t got;

  // Write monitor: pacing, single-cycle strobe, and scoreboard compare.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.uart_write_en) begin
      writes++;
      chk("write_while_busy", {prev_busy, bus.uart_busy}, 0);
      chk("write_en_pulse", prev_we, 0);
      chk("write_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        got = sb.pop_front();
        chk("grant_id", grant_id, got.id);
        chk("uart_data", bus.uart_data, got.data);
        chk("locked", locked, got.locked);
      end
    end
    prev_busy = bus.uart_busy;
    prev_we   = bus.uart_write_en;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_write_en"}, bus.uart_write_en, 0);
    chk({tag, "_uart_data"}, bus.uart_data, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    chk({tag, "_drain"}, sb.size(), 0);
  endtask

  task automatic wait_writes(input int target);
    int i;
    for (i = 0; i < 400 && writes < target; i++) begin
      @(negedge clk);
      #2;
    end
    chk("wait_writes", 32'(writes >= target), 1);
  endtask

  task automatic push(input int src, input logic [7:0] d, input logic last, input exp_t e);
    if (src == 0) q0.push_back({last, d});
    else          q1.push_back({last, d});
    sb.push_back(e);
  endtask

  vec_t tbl[13];
  int   w0;
  int   n;

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{0, 0, 8'h41, 1'b1, '{1'b0, 8'h41, 1'b0}};
    tbl[1]  = '{1, 0, 8'h61, 1'b1, '{1'b1, 8'h62, 1'b0}};
    tbl[2]  = '{1, 1, 8'h62, 1'b1, '{1'b0, 8'h61, 1'b0}};
    tbl[3]  = '{1, 0, 8'h63, 1'b1, '{1'b1, 8'h64, 1'b0}};
    tbl[4]  = '{1, 1, 8'h64, 1'b1, '{1'b0, 8'h63, 1'b0}};
    tbl[5]  = '{2, 0, 8'h41, 1'b0, '{1'b0, 8'h41, 1'b1}};
    tbl[6]  = '{3, 1, 8'h5A, 1'b1, '{1'b0, 8'h42, 1'b1}};
    tbl[7]  = '{4, 0, 8'h42, 1'b0, '{1'b0, 8'h43, 1'b1}};
    tbl[8]  = '{4, 0, 8'h43, 1'b0, '{1'b0, 8'h0D, 1'b0}};
    tbl[9]  = '{4, 0, 8'h0D, 1'b1, '{1'b1, 8'h5A, 1'b0}};
    tbl[10] = '{5, 1, 8'h70, 1'b1, '{1'b1, 8'h70, 1'b0}};
    tbl[11] = '{5, 1, 8'h71, 1'b1, '{1'b1, 8'h71, 1'b0}};
    tbl[12] = '{5, 1, 8'h72, 1'b1, '{1'b1, 8'h72, 1'b0}};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2;
    rst_n = 1'b1;
    fires0 = 0;

    for (int p = 0; p <= 5; p++) begin
      for (int r = 0; r < 13; r++)
        if (tbl[r].phase == p) push(tbl[r].src, tbl[r].d, tbl[r].last, tbl[r].exp);
      if (p == 3) begin
        w0 = writes;
        repeat (30) @(negedge clk);
        chk("lock_hold_writes", writes, w0);
        chk("lock_hold_locked", locked, 1);
        chk("lock_hold_ready1", bus.req_ready[1], 0);
      end else begin
        wait_drain($sformatf("phase%0d", p));
      end
      if (p == 0) begin
        chk("single_ready0_cycles", fires0, 1);
        chk("single_locked", locked, 0);
      end
    end

    // Reset in the middle of a four-byte message.
    repeat (15) @(negedge clk);
    w0 = writes;
    push(0, 8'h31, 1'b0, '{1'b0, 8'h31, 1'b1});
    push(0, 8'h32, 1'b0, '{1'b0, 8'h32, 1'b1});
    q0.push_back({1'b0, 8'h33});
    q0.push_back({1'b1, 8'h34});
    wait_writes(w0 + 2);
    chk("mid_locked_before_rst", locked, 1);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    sb.delete();
    bus.req_valid = '0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    push(1, 8'h52, 1'b1, '{1'b1, 8'h52, 1'b0});
    wait_drain("after_reset");
    repeat (15) @(negedge clk);
    chk("after_reset_idle_locked", locked, 0);

`ifdef UART_ARB_WATCHDOG_EN
    stuck = 1'b1;
    w0 = writes;
    push(0, 8'h57, 1'b1, '{1'b0, 8'h57, 1'b0});
    wait_writes(w0 + 1);
    n = 0;
    while (!err_timeout && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wd_latency", n, 16);
    chk("wd_err", err_timeout, 1);
    push(1, 8'h58, 1'b1, '{1'b1, 8'h58, 1'b0});
    wait_drain("wd_next_byte");
    chk("wd_err_sticky", err_timeout, 1);
`else
    chk("err_timeout_off", err_timeout, 0);
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
